// File: rtl/undither.sv
// undither: rebuilds a BITS_OUT-bit value from a dithered BITS_IN-bit stream
// by keeping a running sum of the last WINDOW samples (WINDOW = 2**EXTRA).
module undither #(
    parameter int BITS_IN  = 4,
    parameter int BITS_OUT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                en,
    input  logic                clear,
    input  logic [BITS_IN-1:0]  data_in,
    output logic [BITS_OUT-1:0] data_out,
    output logic                valid
);

    localparam int EXTRA  = BITS_OUT - BITS_IN;
    localparam int WINDOW = 2 ** EXTRA;
    localparam int CNT_W  = EXTRA + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WINDOW);

    // hist[0] is the newest sample, hist[WINDOW-1] the one about to leave
    logic [WINDOW-1:0][BITS_IN-1:0] hist;
    logic [BITS_OUT-1:0]            sum;
    logic [BITS_OUT-1:0]            sum_next;
    logic [CNT_W-1:0]               cnt;
    logic [CNT_W-1:0]               cnt_next;

    // Next window sum and saturating fill count. The outgoing sample is
    // already part of sum, so the subtraction cannot underflow, and the
    // full-scale sum WINDOW*(2**BITS_IN-1) always fits in BITS_OUT bits.
    always_comb begin
        sum_next = sum + BITS_OUT'(data_in) - BITS_OUT'(hist[WINDOW-1]);
        cnt_next = (cnt == CNT_FULL) ? cnt : cnt + 1'b1;
    end

    // History, sum and fill count advance on every sample regardless of en,
    // so switching back from bypass gives a correct sum with no refill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            sum  <= '0;
            cnt  <= '0;
        end else if (clear) begin
            hist <= '0;
            sum  <= '0;
            cnt  <= '0;
        end else if (ce) begin
            hist <= {hist[WINDOW-2:0], data_in};
            sum  <= sum_next;
            cnt  <= cnt_next;
        end
    end

    // Registered output: window sum when enabled, zero-padded sample in bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (clear) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (ce) begin
            data_out <= en ? sum_next : {data_in, {EXTRA{1'b0}}};
            valid    <= (cnt_next == CNT_FULL);
        end
    end

endmodule

// File: tb/tb_undither.sv
// Directed bench for undither with BITS_IN=4, BITS_OUT=8 (WINDOW=16).
module tb_undither;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       en;
    logic       clear;
    logic [3:0] data_in;
    logic [7:0] data_out;
    logic       valid;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    undither #(.BITS_IN(4), .BITS_OUT(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .en       (en),
        .clear    (clear),
        .data_in  (data_in),
        .data_out (data_out),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs, take the edge, sample 1 time unit later
    task automatic tick(input logic c, input logic e, input logic cl, input logic [3:0] d);
        ce = c; en = e; clear = cl; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; en = 1'b1; clear = 1'b0; data_in = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_data", 32'(data_out), 0);
        check("reset_valid", 32'(valid), 0);
        reset = 1'b0;

        // Idle after release: nothing moves without ce
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 4'hF);
        check("idle_data", 32'(data_out), 0);
        check("idle_valid", 32'(valid), 0);

        // Constant fill with 9: ramps 9,18,..,144 then holds
        for (int k = 1; k <= 20; k++) begin
            tick(1'b1, 1'b1, 1'b0, 4'd9);
            check($sformatf("fill_data_%0d", k), 32'(data_out), (k < 16 ? k : 16) * 9);
            check($sformatf("fill_valid_%0d", k), 32'(valid), (k >= 16) ? 1 : 0);
        end

        // Dither pattern 8x9 then 8x10, twice; any full window sums to 152
        for (int k = 1; k <= 32; k++) begin
            tick(1'b1, 1'b1, 1'b0, (((k - 1) / 8) % 2 == 0) ? 4'd9 : 4'd10);
            if (k >= 16) check($sformatf("dither_%0d", k), 32'(data_out), 152);
        end

        // Full scale: 16 x 15 = 240, no wrap
        for (int k = 1; k <= 16; k++) tick(1'b1, 1'b1, 1'b0, 4'd15);
        check("fullscale_data", 32'(data_out), 240);
        check("fullscale_valid", 32'(valid), 1);

        // ce gap: outputs hold while data_in wiggles
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 4'(i));
        check("gap_data", 32'(data_out), 240);
        check("gap_valid", 32'(valid), 1);

        // Bypass: 0xA padded to 0xA0; history still takes the sample
        tick(1'b1, 1'b0, 1'b0, 4'hA);
        check("bypass_data", 32'(data_out), 8'hA0);
        check("bypass_valid", 32'(valid), 1);

        // Back to reconstruct: window = 14x15 + 10 + 15 = 235
        tick(1'b1, 1'b1, 1'b0, 4'd15);
        check("reen_data", 32'(data_out), 235);

        // clear beats ce; data_in=7 not captured
        tick(1'b1, 1'b1, 1'b1, 4'd7);
        check("clear_data", 32'(data_out), 0);
        check("clear_valid", 32'(valid), 0);
        for (int k = 1; k <= 16; k++) begin
            tick(1'b1, 1'b1, 1'b0, 4'd7);
            if (k == 1 || k >= 15) begin
                check($sformatf("refill_data_%0d", k), 32'(data_out), k * 7);
                check($sformatf("refill_valid_%0d", k), 32'(valid), (k == 16) ? 1 : 0);
            end
        end

        // Asynchronous reset mid-cycle takes effect without a clock edge
        #3;
        reset = 1'b1;
        #1;
        check("async_data", 32'(data_out), 0);
        check("async_valid", 32'(valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 4'd3);
        check("postrst_idle", 32'(data_out), 0);

        // History was discarded: first sample alone
        tick(1'b1, 1'b1, 1'b0, 4'd5);
        check("postrst_first", 32'(data_out), 5);
        check("postrst_valid", 32'(valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
